// File: rtl/sram_axi_bridge_pkg.sv
// rtl/sram_axi_bridge_pkg.sv - shared IDs, FSM encodings and size mapping for the SRAM-to-AXI bridge
//
// Purpose: common definitions imported by sram_axi_bridge and axi_wr_ctrl.
//   AXI_INST_ID / AXI_DATA_ID : default AXI IDs for instruction and data traffic
//   ar_state_t                : read-address channel states
//   w_state_t                 : write channel states
//   size_to_axsize            : SRAM size code (0=1B,1=2B,2=4B) to AXI AxSIZE
package sram_axi_bridge_pkg;

  localparam logic [3:0] AXI_INST_ID = 4'd0;
  localparam logic [3:0] AXI_DATA_ID = 4'd1;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_axi_wr_ctrl.sv
// rtl/sram_axi_bridge_axi_wr_ctrl.sv - single-beat AXI write sequencer (AW/W/B) for the data port
//
// Purpose: latches one data-port write on start, drives AW and W independently
// until each completes, then waits for B and reports completion.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   start                           : write accepted this cycle (only sampled in W_IDLE)
//   req_addr/size/wstrb/wdata       : write request fields from the data port
//   awaddr, awsize, awvalid, awready: write address channel
//   wdata, wstrb, wvalid, wready    : write data channel
//   bvalid                          : write response valid (bready is tied high at the top)
//   busy                            : a write is in flight (state != W_IDLE)
//   data_ok                         : one-cycle write completion to the core
module axi_wr_ctrl
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        busy,
  output logic        data_ok
);

  w_state_t state, state_next;
  logic     aw_done, w_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= W_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // AW and W retire independently; the phase ends once both have been seen,
  // whether that happens in the same cycle or in different cycles.
  always_comb begin
    state_next = state;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    data_ok    = 1'b0;
    busy       = (state != W_IDLE);
    case (state)
      W_IDLE: begin
        if (start) state_next = W_ADDR;
      end
      W_ADDR: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        if ((aw_done | awready) && (w_done | wready)) state_next = W_RESP;
      end
      W_RESP: begin
        if (bvalid) begin
          data_ok    = 1'b1;
          state_next = W_IDLE;
        end
      end
      default: state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      awaddr  <= 32'd0;
      awsize  <= 3'd0;
      wdata   <= 32'd0;
      wstrb   <= 4'd0;
    end else if (state == W_IDLE) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      if (start) begin
        awaddr <= req_addr;
        awsize <= size_to_axsize(req_size);
        wdata  <= req_wdata;
        wstrb  <= req_wstrb;
      end
    end else if (state == W_ADDR) begin
      if (awready) aw_done <= 1'b1;
      if (wready)  w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - instruction/data SRAM-like ports to a single AXI3 master
//
// Purpose: arbitrates the shared AR channel between the IF and MEM ports, tracks
// one outstanding transaction per source, demuxes R by ID and hands data-port
// writes to axi_wr_ctrl.
// Ports:
//   clk, reset                              : clock, synchronous active-high reset
//   inst_sram_*                             : instruction port (read only; wr/wstrb/wdata ignored)
//   data_sram_*                             : data port (read or write)
//   arid/araddr/arsize/arvalid/arready      : read address channel
//   arlen/arburst/arlock/arcache/arprot     : read address constants
//   rid/rdata/rvalid/rready                 : read data channel (rready tied high)
//   awid/awaddr/awsize/awvalid/awready      : write address channel
//   awlen/awburst                           : write address constants
//   wid/wdata/wstrb/wlast/wvalid/wready     : write data channel
//   bvalid/bready                           : write response (bready tied high)
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = AXI_INST_ID,
  parameter logic [3:0] DATA_ID = AXI_DATA_ID
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  ar_state_t ar_state, ar_next;
  logic      inst_pend, data_pend;
  logic      ar_idle;
  logic      data_rd_grant, data_wr_start, inst_grant;
  logic      data_pend_write;
  logic      r_inst, r_data, b_hs;
  logic      w_busy, w_data_ok;
  logic      unused;

  assign unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata};

  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = DATA_ID;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign wid     = 4'd1;
  assign wlast   = 1'b1;
  assign rready  = 1'b1;
  assign bready  = 1'b1;

  assign ar_idle = (ar_state == AR_IDLE);

  // Writes also wait for AR_IDLE so a data write never races a data read that
  // is still presenting its address.
  assign data_rd_grant   = ar_idle & data_sram_req & ~data_sram_wr & ~data_pend;
  assign data_wr_start   = ar_idle & data_sram_req &  data_sram_wr & ~data_pend;
  // An in-flight data write may be modifying code; hold instruction fetches off.
  assign data_pend_write = data_pend & w_busy;
  assign inst_grant      = ar_idle & inst_sram_req & ~inst_pend & ~data_pend_write & ~data_rd_grant;

  assign r_inst = rvalid & rready & (rid == INST_ID);
  assign r_data = rvalid & rready & (rid == DATA_ID);
  assign b_hs   = bvalid & bready;

  assign inst_sram_addr_ok = inst_grant;
  assign data_sram_addr_ok = data_rd_grant | data_wr_start;
  assign inst_sram_data_ok = r_inst;
  assign data_sram_data_ok = r_data | w_data_ok;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state <= AR_IDLE;
    end else begin
      ar_state <= ar_next;
    end
  end

  always_comb begin
    ar_next = ar_state;
    arvalid = 1'b0;
    case (ar_state)
      AR_IDLE: begin
        if (data_rd_grant | inst_grant) ar_next = AR_BUSY;
      end
      AR_BUSY: begin
        arvalid = 1'b1;
        if (arready) ar_next = AR_IDLE;
      end
      default: ar_next = AR_IDLE;
    endcase
  end

  // Address fields are only loaded on a grant, so they stay frozen while
  // arvalid waits for arready.
  always_ff @(posedge clk) begin
    if (reset) begin
      arid   <= 4'd0;
      araddr <= 32'd0;
      arsize <= 3'd0;
    end else if (data_rd_grant) begin
      arid   <= DATA_ID;
      araddr <= data_sram_addr;
      arsize <= size_to_axsize(data_sram_size);
    end else if (inst_grant) begin
      arid   <= INST_ID;
      araddr <= inst_sram_addr;
      arsize <= size_to_axsize(inst_sram_size);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_pend <= 1'b0;
      data_pend <= 1'b0;
    end else begin
      if (inst_grant)  inst_pend <= 1'b1;
      else if (r_inst) inst_pend <= 1'b0;
      if (data_rd_grant | data_wr_start) data_pend <= 1'b1;
      else if (r_data | b_hs)            data_pend <= 1'b0;
    end
  end

  axi_wr_ctrl u_wr_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start     (data_wr_start),
    .req_addr  (data_sram_addr),
    .req_size  (data_sram_size),
    .req_wstrb (data_sram_wstrb),
    .req_wdata (data_sram_wdata),
    .awaddr    (awaddr),
    .awsize    (awsize),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .busy      (w_busy),
    .data_ok   (w_data_ok)
  );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - self-checking bench for sram_axi_bridge
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [3:0]  awid, awlen;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2; inst_sram_addr = 32'd0;
    inst_sram_wstrb = 4'd0; inst_sram_wdata = 32'd0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2; data_sram_addr = 32'd0;
    data_sram_wstrb = 4'd0; data_sram_wdata = 32'd0;
    arready = 1'b0; rvalid = 1'b0; rid = 4'd0; rdata = 32'd0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  task automatic nx();
    @(posedge clk); #1;
  endtask

  task automatic sm();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_in();
    nx(); nx();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        ir, dr, dw;
    logic        eio, edo, earv;
    logic [3:0]  earid;
    logic        eawv;
    logic [31:0] earaddr;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic dr, input logic dw, input logic eio,
                              input logic edo, input logic earv, input logic [3:0] earid,
                              input logic eawv, input logic [31:0] earaddr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.eio = eio; v.edo = edo; v.earv = earv;
    v.earid = earid; v.eawv = eawv; v.earaddr = earaddr;
    return v;
  endfunction

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
  } rq_t;

  localparam logic [31:0] RKEY = 32'ha5a5_5a5a;

  vec_t vt[6];

  initial begin
    vt[0] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
    vt[1] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 32'h1c00_0040);
    vt[2] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 32'h0000_0200);
    vt[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 32'h0000_0200);
    vt[4] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 32'h0);
    vt[5] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 32'h1c00_0040);

    // reset state
    do_reset();
    sm();
    chk("rst_arvalid", arvalid, 0); chk("rst_awvalid", awvalid, 0); chk("rst_wvalid", wvalid, 0);
    chk("rst_inst_addr_ok", inst_sram_addr_ok, 0); chk("rst_data_addr_ok", data_sram_addr_ok, 0);
    chk("rst_inst_data_ok", inst_sram_data_ok, 0); chk("rst_data_data_ok", data_sram_data_ok, 0);
    chk("rst_rready", rready, 1); chk("rst_bready", bready, 1);
    chk("rst_araddr", araddr, 0); chk("rst_awaddr", awaddr, 0); chk("rst_wdata", wdata, 0);
    chk("const_arlen", arlen, 0); chk("const_arburst", arburst, 1); chk("const_awburst", awburst, 1);
    chk("const_wlast", wlast, 1); chk("const_wid", wid, 1); chk("const_awid", awid, 1);

    // table: arbitration from idle
    for (int i = 0; i < 6; i++) begin
      do_reset();
      inst_sram_req = vt[i].ir; inst_sram_addr = 32'h1c00_0040;
      data_sram_req = vt[i].dr; data_sram_wr = vt[i].dw; data_sram_addr = 32'h0000_0200;
      sm();
      chk($sformatf("vec%0d_inst_addr_ok", i), inst_sram_addr_ok, vt[i].eio);
      chk($sformatf("vec%0d_data_addr_ok", i), data_sram_addr_ok, vt[i].edo);
      nx();
      inst_sram_req = 1'b0; data_sram_req = 1'b0;
      sm();
      chk($sformatf("vec%0d_arvalid", i), arvalid, vt[i].earv);
      chk($sformatf("vec%0d_arid", i), arid, vt[i].earid);
      chk($sformatf("vec%0d_araddr", i), araddr, vt[i].earaddr);
      chk($sformatf("vec%0d_awvalid", i), awvalid, vt[i].eawv);
    end

    // basic inst read
    do_reset();
    arready = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000;
    sm(); chk("ir_addr_ok", inst_sram_addr_ok, 1);
    nx(); inst_sram_req = 1'b0;
    sm(); chk("ir_arvalid", arvalid, 1); chk("ir_araddr", araddr, 32'h1c00_0000);
    chk("ir_arsize", arsize, 2); chk("ir_arid", arid, 0);
    nx(); sm(); chk("ir_arvalid_drop", arvalid, 0); chk("ir_no_early_ok", inst_sram_data_ok, 0);
    nx(); nx(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0c0c;
    sm(); chk("ir_data_ok", inst_sram_data_ok, 1); chk("ir_rdata", inst_sram_rdata, 32'h0280_0c0c);
    chk("ir_data_side_quiet", data_sram_data_ok, 0);
    nx(); rvalid = 1'b0;

    // same-cycle inst + data read, out-of-order return
    do_reset();
    arready = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0010;
    data_sram_req = 1'b1; data_sram_addr = 32'h0000_0080;
    sm(); chk("arb_inst_ok", inst_sram_addr_ok, 0); chk("arb_data_ok", data_sram_addr_ok, 1);
    nx(); data_sram_req = 1'b0;
    sm(); chk("arb_arid_data", arid, 1); chk("arb_araddr_data", araddr, 32'h80);
    chk("arb_inst_blocked_busy", inst_sram_addr_ok, 0);
    nx(); sm(); chk("arb_inst_ok_after", inst_sram_addr_ok, 1);
    nx(); inst_sram_req = 1'b0;
    sm(); chk("arb_arvalid_inst", arvalid, 1); chk("arb_arid_inst", arid, 0);
    nx(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h1111_1111;
    sm(); chk("ooo_inst_ok", inst_sram_data_ok, 1); chk("ooo_data_not", data_sram_data_ok, 0);
    nx(); rid = 4'd1; rdata = 32'h2222_2222;
    sm(); chk("ooo_inst_not", inst_sram_data_ok, 0); chk("ooo_data_ok", data_sram_data_ok, 1);
    chk("ooo_data_rdata", data_sram_rdata, 32'h2222_2222);
    nx(); rvalid = 1'b0;

    // data write with late awready; inst read held off until after B
    do_reset();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h100;
    data_sram_wdata = 32'hdead_beef; data_sram_wstrb = 4'hf; wready = 1'b1;
    sm(); chk("wr_addr_ok", data_sram_addr_ok, 1);
    nx(); data_sram_req = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0020;
    sm(); chk("wr_awvalid1", awvalid, 1); chk("wr_wvalid1", wvalid, 1);
    chk("wr_awaddr", awaddr, 32'h100); chk("wr_awsize", awsize, 2);
    chk("wr_wdata", wdata, 32'hdead_beef); chk("wr_wstrb", wstrb, 4'hf);
    chk("wr_inst_blk1", inst_sram_addr_ok, 0);
    nx(); sm(); chk("wr_awvalid2", awvalid, 1); chk("wr_wvalid2", wvalid, 0);
    nx(); awready = 1'b1;
    sm(); chk("wr_awvalid3", awvalid, 1); chk("wr_no_ok3", data_sram_data_ok, 0);
    nx(); awready = 1'b0;
    sm(); chk("wr_awvalid4", awvalid, 0); chk("wr_no_ok4", data_sram_data_ok, 0);
    chk("wr_inst_blk4", inst_sram_addr_ok, 0);
    nx(); bvalid = 1'b1;
    sm(); chk("wr_data_ok", data_sram_data_ok, 1); chk("wr_inst_blk_b", inst_sram_addr_ok, 0);
    nx(); bvalid = 1'b0;
    sm(); chk("wr_ok_drop", data_sram_data_ok, 0); chk("wr_inst_free", inst_sram_addr_ok, 1);
    nx(); inst_sram_req = 1'b0;
    sm(); chk("wr_then_ar", arvalid, 1); chk("wr_then_araddr", araddr, 32'h1c00_0020);

    // inst pending + arready stall
    do_reset();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0030; inst_sram_size = 2'd1;
    sm(); chk("st_addr_ok", inst_sram_addr_ok, 1);
    nx(); inst_sram_addr = 32'h1c00_0034; inst_sram_size = 2'd2;
    for (int k = 0; k < 5; k++) begin
      sm();
      chk($sformatf("st_arvalid%0d", k), arvalid, 1);
      chk($sformatf("st_araddr%0d", k), araddr, 32'h1c00_0030);
      chk($sformatf("st_arsize%0d", k), arsize, 1);
      chk($sformatf("st_arid%0d", k), arid, 0);
      chk($sformatf("st_inst_blk%0d", k), inst_sram_addr_ok, 0);
      nx();
    end
    arready = 1'b1;
    sm(); chk("st_arvalid_hs", arvalid, 1);
    nx(); arready = 1'b0;
    sm(); chk("st_arvalid_done", arvalid, 0); chk("st_pend_blk", inst_sram_addr_ok, 0);
    nx(); rvalid = 1'b1; rid = 4'd0;
    sm(); chk("st_ret_ok", inst_sram_data_ok, 1); chk("st_ret_blk", inst_sram_addr_ok, 0);
    nx(); rvalid = 1'b0;
    sm(); chk("st_reaccept", inst_sram_addr_ok, 1);

    // reset while AR_BUSY and W_RESP
    do_reset();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0040;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h200; data_sram_wdata = 32'h1234_5678;
    sm(); chk("mr_inst_ok", inst_sram_addr_ok, 1); chk("mr_data_ok", data_sram_addr_ok, 1);
    nx(); inst_sram_req = 1'b0; data_sram_req = 1'b0; awready = 1'b1; wready = 1'b1;
    sm(); chk("mr_arvalid", arvalid, 1); chk("mr_awvalid", awvalid, 1); chk("mr_wvalid", wvalid, 1);
    nx(); awready = 1'b0; wready = 1'b0;
    sm(); chk("mr_wresp_aw", awvalid, 0); chk("mr_busy_ar", arvalid, 1);
    nx(); reset = 1'b1;
    nx(); reset = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0050;
    sm(); chk("mr_post_arvalid", arvalid, 0); chk("mr_post_awvalid", awvalid, 0);
    chk("mr_post_wvalid", wvalid, 0); chk("mr_post_inst_ok", inst_sram_addr_ok, 1);
    nx(); inst_sram_req = 1'b0;
    sm(); chk("mr_post_ar", arvalid, 1); chk("mr_post_araddr", araddr, 32'h1c00_0050);

    // randomized traffic against a transaction-level model
    begin
      rq_t         rq[$];
      bit          m_inst_out = 0, m_data_out = 0, m_data_wr = 0, m_ar_full = 0;
      bit          m_aw_pend = 0, m_w_pend = 0, m_wr_active = 0, m_b_armed = 0;
      logic [31:0] m_ar_addr = 0, m_inst_addr = 0, m_data_addr = 0, m_aw_addr = 0, m_wdata = 0;
      logic [3:0]  m_ar_id = 0, m_wstrb = 0;
      logic [2:0]  m_ar_size = 0, m_aw_size = 0;
      bit          e_drd, e_dwr, e_ird, e_ido, e_rdd;
      do_reset();
      for (int c = 0; c < 800; c++) begin
        nx();
        inst_sram_req  = 1'($urandom);
        inst_sram_wr   = 1'($urandom);
        inst_sram_size = 2'($urandom_range(0, 2));
        inst_sram_addr = $urandom;
        data_sram_req  = 1'($urandom);
        data_sram_wr   = 1'($urandom);
        data_sram_size = 2'($urandom_range(0, 2));
        data_sram_addr = $urandom;
        data_sram_wdata = $urandom;
        data_sram_wstrb = 4'($urandom);
        arready = 1'($urandom); awready = 1'($urandom); wready = 1'($urandom);
        if (rq.size() > 0 && $urandom_range(0, 2) == 0) begin
          int idx;
          idx = int'($urandom_range(0, rq.size() - 1));
          rvalid = 1'b1; rid = rq[idx].id; rdata = rq[idx].addr ^ RKEY;
          rq.delete(idx);
        end else begin
          rvalid = 1'b0; rid = 4'($urandom); rdata = $urandom;
        end
        bvalid = m_b_armed && ($urandom_range(0, 1) == 1);
        sm();
        e_drd = data_sram_req & ~data_sram_wr & ~m_data_out & ~m_ar_full;
        e_dwr = data_sram_req &  data_sram_wr & ~m_data_out & ~m_ar_full;
        e_ird = inst_sram_req & ~m_inst_out & ~m_ar_full & ~(m_data_out & m_data_wr) & ~e_drd;
        e_ido = rvalid & (rid == 4'd0);
        e_rdd = rvalid & (rid == 4'd1);
        chk("rnd_inst_addr_ok", inst_sram_addr_ok, e_ird);
        chk("rnd_data_addr_ok", data_sram_addr_ok, e_drd | e_dwr);
        chk("rnd_arvalid", arvalid, m_ar_full);
        if (m_ar_full) begin
          chk("rnd_araddr", araddr, m_ar_addr); chk("rnd_arid", arid, m_ar_id); chk("rnd_arsize", arsize, m_ar_size);
        end
        chk("rnd_awvalid", awvalid, m_aw_pend);
        chk("rnd_wvalid", wvalid, m_w_pend);
        if (m_aw_pend) begin
          chk("rnd_awaddr", awaddr, m_aw_addr); chk("rnd_awsize", awsize, m_aw_size);
        end
        if (m_w_pend) begin
          chk("rnd_wdata", wdata, m_wdata); chk("rnd_wstrb", wstrb, m_wstrb);
        end
        chk("rnd_inst_data_ok", inst_sram_data_ok, e_ido);
        chk("rnd_data_data_ok", data_sram_data_ok, e_rdd | bvalid);
        if (e_ido) chk("rnd_inst_rdata", inst_sram_rdata, m_inst_addr ^ RKEY);
        if (e_rdd) chk("rnd_data_rdata", data_sram_rdata, m_data_addr ^ RKEY);
        // advance the model by one cycle
        if (m_ar_full && arready) begin
          rq_t r;
          r.id = m_ar_id; r.addr = m_ar_addr;
          rq.push_back(r);
          m_ar_full = 0;
        end
        if (e_ido) m_inst_out = 0;
        if (e_rdd) m_data_out = 0;
        if (bvalid) begin
          m_b_armed = 0; m_data_out = 0; m_wr_active = 0;
        end
        if (m_aw_pend && awready) m_aw_pend = 0;
        if (m_w_pend && wready) m_w_pend = 0;
        if (m_wr_active && !m_aw_pend && !m_w_pend && !m_b_armed && !bvalid) m_b_armed = 1;
        if (e_drd) begin
          m_ar_full = 1; m_ar_addr = data_sram_addr; m_ar_id = 4'd1; m_ar_size = {1'b0, data_sram_size};
          m_data_out = 1; m_data_wr = 0; m_data_addr = data_sram_addr;
        end else if (e_ird) begin
          m_ar_full = 1; m_ar_addr = inst_sram_addr; m_ar_id = 4'd0; m_ar_size = {1'b0, inst_sram_size};
          m_inst_out = 1; m_inst_addr = inst_sram_addr;
        end
        if (e_dwr) begin
          m_data_out = 1; m_data_wr = 1; m_wr_active = 1; m_aw_pend = 1; m_w_pend = 1;
          m_aw_addr = data_sram_addr; m_aw_size = {1'b0, data_sram_size};
          m_wdata = data_sram_wdata; m_wstrb = data_sram_wstrb;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
